// File: rtl/inst_cache_if.sv
// Fetch and refill bus between the CPU, the instruction cache and instruction memory.
// Purely structural: no storage, no added latency.
// The cache (slave) stalls the CPU through busywait; memory stalls the cache through mem_busywait.
interface inst_cache_if #(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 3
);
   logic [31:0]                    pc;
   logic [31:0]                    instruction;
   logic                           busywait;
   logic                           mem_read;
   logic [TAG_BITS+INDEX_BITS-1:0] mem_address;
   logic [127:0]                   mem_readdata;
   logic                           mem_busywait;

   // CPU fetch port plus instruction memory, as seen from outside the cache
   modport master (
      output pc,
      input  instruction,
      input  busywait,
      input  mem_read,
      input  mem_address,
      output mem_readdata,
      output mem_busywait
   );

   // The cache: responder on the fetch port, requester on the refill port
   modport slave (
      input  pc,
      output instruction,
      output busywait,
      input  mem_readdata,
      input  mem_busywait,
      output mem_read,
      output mem_address
   );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache, 16-byte blocks, refilled from instruction memory; optional ICACHE_STATS_EN adds hit/miss counters.
// Latency: hit 0 cycles; miss 1 detect + k memory cycles + 1 update before the word is served.
// Backpressure: busywait stalls the CPU on a miss; mem_busywait holds the cache in MEM_READ.
module inst_cache #(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 3
) (
   input  logic          i_clk,
   input  logic          i_reset,
   inst_cache_if.slave   if_bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]   o_hit_count,
   output logic [15:0]   o_miss_count
`endif
);
   localparam int NUM_BLOCKS = 1 << INDEX_BITS;
   localparam int AW         = TAG_BITS + INDEX_BITS;
   localparam int TAG_LSB    = INDEX_BITS + 4;
   localparam int TAG_MSB    = TAG_BITS + INDEX_BITS + 3;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_UPDATE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [NUM_BLOCKS-1:0] r_valid;
   logic [TAG_BITS-1:0]   r_tag  [NUM_BLOCKS];
   logic [127:0]          r_data [NUM_BLOCKS];
   logic [AW-1:0]         r_miss_addr;
   logic [127:0]          r_block;

   logic [1:0]            w_offset;
   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_BITS-1:0]   w_tag;
   logic                  w_hit;
   logic [127:0]          w_line;
   logic [31:0]           w_word;
   logic [INDEX_BITS-1:0] w_miss_index;
   logic [TAG_BITS-1:0]   w_miss_tag;

   // Byte offset and the address bits above the tag never influence the lookup
   logic w_unused_pc_bits;
   assign w_unused_pc_bits = ^{if_bus.pc[1:0], if_bus.pc[31:TAG_MSB+1]};

   assign w_offset     = if_bus.pc[3:2];
   assign w_index      = if_bus.pc[INDEX_BITS+3:4];
   assign w_tag        = if_bus.pc[TAG_MSB:TAG_LSB];
   assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_line       = r_data[w_index];
   assign w_miss_index = r_miss_addr[INDEX_BITS-1:0];
   assign w_miss_tag   = r_miss_addr[AW-1:INDEX_BITS];

   // Select the requested word out of the indexed block
   always_comb begin
      w_word = w_line[31:0];
      case (w_offset)
         2'd1:    w_word = w_line[63:32];
         2'd2:    w_word = w_line[95:64];
         2'd3:    w_word = w_line[127:96];
         default: w_word = w_line[31:0];
      endcase
   end

   // State register; reset abandons any refill in flight
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state: miss starts a refill, memory release ends it, update returns to lookup
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:     if (!w_hit) w_next_state = S_MEM_READ;
         S_MEM_READ: if (!if_bus.mem_busywait) w_next_state = S_UPDATE;
         S_UPDATE:   w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   // Fetch-port and refill-port outputs; everything is held quiet during reset
   always_comb begin
      if_bus.busywait    = 1'b0;
      if_bus.instruction = 32'h0;
      if_bus.mem_read    = 1'b0;
      if_bus.mem_address = '0;
      if (!i_reset) begin
         if_bus.busywait    = (r_state != S_IDLE) || !w_hit;
         if_bus.mem_read    = (r_state == S_MEM_READ);
         if_bus.mem_address = r_miss_addr;
         if ((r_state == S_IDLE) && w_hit) if_bus.instruction = w_word;
      end
   end

   // Latch the missing block address so the refill ignores later PC activity
   always_ff @(posedge i_clk) begin
      if (i_reset)                          r_miss_addr <= '0;
      else if ((r_state == S_IDLE) && !w_hit) r_miss_addr <= {w_tag, w_index};
   end

   // Capture the refill block in the cycle memory releases busywait
   always_ff @(posedge i_clk) begin
      if ((r_state == S_MEM_READ) && !if_bus.mem_busywait) r_block <= if_bus.mem_readdata;
   end

   // Valid and tag are only committed in UPDATE, so an aborted refill leaves no trace
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= '0;
      end else if (r_state == S_UPDATE) begin
         r_valid[w_miss_index] <= 1'b1;
         r_tag[w_miss_index]   <= w_miss_tag;
      end
   end

   // Block data array; contents are meaningless until the matching valid bit is set
   always_ff @(posedge i_clk) begin
      if (!i_reset && (r_state == S_UPDATE)) r_data[w_miss_index] <= r_block;
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   // Saturating counters of served hits and started refills
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hit_count  <= 16'h0;
         r_miss_count <= 16'h0;
      end else if (r_state == S_IDLE) begin
         if (w_hit && (r_hit_count != 16'hFFFF))    r_hit_count  <= r_hit_count + 16'h1;
         if (!w_hit && (r_miss_count != 16'hFFFF))  r_miss_count <= r_miss_count + 16'h1;
      end
   end

   assign o_hit_count  = r_hit_count;
   assign o_miss_count = r_miss_count;
`endif
endmodule

// File: doc/inst_cache.md
# inst_cache

- Direct-mapped instruction cache between the CPU fetch port and the instruction memory.
- Serves `INSTRUCTION` for the CPU's `PC` with no stall on a hit.
- On a miss, asserts `BUSYWAIT` to stall the CPU, refills one 16-byte block from instruction memory through a read/busywait handshake, then serves the word.
- It is the responder for the CPU's `PC`/`INSTRUCTION` fetch interface.

## Interface
- `INDEX_BITS`, default 3: number of index bits; the cache holds 2^INDEX_BITS blocks.
- `TAG_BITS`, default 3: number of tag bits. The cache decodes `PC[TAG_BITS+INDEX_BITS+3:0]`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `PC` in 32: fetch address from the CPU.
- `INSTRUCTION` out 32: fetched word; valid whenever `BUSYWAIT`=0.
- `BUSYWAIT` out 1: CPU stall request.
- `MEM_READ` out 1: block read request to instruction memory.
- `MEM_ADDRESS` out TAG_BITS+INDEX_BITS: block address, `{tag,index}`.
- `MEM_READDATA` in 128: refill block. Word i is at bits [32i+31:32i].
- `MEM_BUSYWAIT` in 1: memory busy; data is valid in the cycle it is low during a read.

## Operation

**Address split**
- `PC[1:0]`: ignored.
- `PC[3:2]`: word offset.
- `PC[INDEX_BITS+3:4]`: index.
- Next `TAG_BITS` bits: tag.
- Higher bits: ignored.

**Storage, per block**
- One valid bit, a `TAG_BITS` tag, and 128 data bits.

**Hit**
- Hit = `valid[index]` && `tag[index]`==PC tag.
- Evaluated combinationally from the current `PC`.

**FSM states**
- IDLE
  - On hit: `BUSYWAIT`=0; `INSTRUCTION` = selected word (combinational).
  - On miss: `BUSYWAIT`=1; latch `{tag,index}` into the miss-address register; next state MEM_READ.
- MEM_READ
  - `MEM_READ`=1; `MEM_ADDRESS` = latched miss address; `BUSYWAIT`=1.
  - Stay while `MEM_BUSYWAIT`=1.
  - On an edge where `MEM_BUSYWAIT`=0: capture `MEM_READDATA`, then go to UPDATE.
- UPDATE
  - Write the captured block, the tag, and valid=1 at the latched index.
  - `MEM_READ`=0; `BUSYWAIT`=1; next state IDLE.

**Protocol rules**
- The CPU holds `PC` stable while `BUSYWAIT`=1.
- The cache uses only the latched miss address from MEM_READ onward.
- Memory asserts `MEM_BUSYWAIT` in the same cycle `MEM_READ` rises.
- `MEM_READ` and `MEM_ADDRESS` are Moore outputs of the state and latch registers.
- A miss never overwrites a block until UPDATE.

**Reset**
- All valid bits cleared; state=IDLE; miss-address register cleared.
- While `RESET`=1: `BUSYWAIT`=0, `MEM_READ`=0, `MEM_ADDRESS`=0, `INSTRUCTION`=32'h0.
- Reset during MEM_READ or UPDATE aborts the refill. No block is written; the memory response is ignored.
- First cycle after reset release: IDLE; every access misses.

## Timing
- Hit: zero-cycle latency; `INSTRUCTION` valid in the same cycle as `PC`.
- Miss with memory busy for k≥1 MEM_READ cycles:
  - 1 cycle IDLE (detect), k cycles MEM_READ, 1 cycle UPDATE.
  - Then IDLE hit, with `BUSYWAIT` low in cycle k+2 after detection.
- `MEM_READ` high for exactly k cycles per refill.
- `MEM_ADDRESS` is constant throughout a refill.
- Back-to-back misses: each refill returns to IDLE for one cycle (hit cycle) before the next miss is detected.
- No pipelining; at most one outstanding memory read.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `HIT_COUNT` out 16 and `MISS_COUNT` out 16, both reset to 0.
  - `HIT_COUNT` increments on every clock edge in IDLE with a hit and `RESET`=0.
  - `MISS_COUNT` increments on every IDLE→MEM_READ transition.
  - Both saturate at 16'hFFFF.
  - The post-refill hit cycle counts as a hit.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Cold miss.** Reset, release, `PC`=32'h0, memory k=5 returning 128'h0000000D_0000000C_0000000B_0000000A.
  - `BUSYWAIT`=1 for 7 cycles; `MEM_READ` high 5 cycles with `MEM_ADDRESS`=0.
  - Then `INSTRUCTION`=32'h0000000A with `BUSYWAIT`=0.
- **Same-block hits.** After the cold miss, `PC`=4, 8, 12.
  - `INSTRUCTION`=0B, 0C, 0D in consecutive cycles; `BUSYWAIT`=0; `MEM_READ` never asserted.
- **Conflict eviction.** `PC`=32'h80 (same index 0, tag 1) after the above.
  - Miss; `MEM_ADDRESS`=6'b001000.
  - A later `PC`=0 misses again.
- **Reset mid-refill.** `RESET` pulsed during cycle 2 of MEM_READ.
  - Next cycle `MEM_READ`=0, state IDLE.
  - Re-access of the same `PC` misses (valid cleared).
- **Ignored bits.** `PC`=32'hFFFFFC03 versus 32'h00000003.
  - Same block/word (`PC[1:0]` and bits above bit 9 ignored); the second access hits.
- **Stats (`ICACHE_STATS_EN`).** The cold-miss and hit sequence above.
  - `MISS_COUNT`=1; `HIT_COUNT`=4.
  - Forced counter at 16'hFFFF stays 16'hFFFF after a further hit.
